// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key decoder: FSM encoding, letter indices
// and default timing parameters.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV   = 1000;
  localparam int DEF_DASH_UNITS = 2;
  localparam int DEF_LETTER_GAP = 3;
  localparam int DEF_CNT_W      = 8;

  localparam logic [4:0] LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3;
  localparam logic [4:0] LTR_E = 5'd4,  LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7;
  localparam logic [4:0] LTR_I = 5'd8,  LTR_J = 5'd9,  LTR_K = 5'd10, LTR_L = 5'd11;
  localparam logic [4:0] LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14, LTR_P = 5'd15;
  localparam logic [4:0] LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19;
  localparam logic [4:0] LTR_U = 5'd20, LTR_V = 5'd21, LTR_W = 5'd22, LTR_X = 5'd23;
  localparam logic [4:0] LTR_Y = 5'd24, LTR_Z = 5'd25;

endpackage

// File: rtl/morse_key_decoder_if.sv
// Key input and letter/strobe outputs of the Morse key decoder.
interface morse_key_decoder_if;
  logic       key;
  logic [4:0] letter;
  logic       letter_valid;
  logic       error;
  logic       busy;

  modport slave  (input key,  output letter, letter_valid, error, busy);
  modport master (output key, input  letter, letter_valid, error, busy);
endinterface

// File: rtl/morse_code_lut.sv
// Maps a symbol count and dot/dash pattern (first symbol most significant)
// to a letter index; valid is low for unassigned codes.
module morse_code_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [3:0] pattern,
  output logic [4:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = LTR_A;
    valid = 1'b1;
    case ({len, pattern})
      {3'd1, 4'b0000}: idx = LTR_E;
      {3'd1, 4'b0001}: idx = LTR_T;
      {3'd2, 4'b0000}: idx = LTR_I;
      {3'd2, 4'b0001}: idx = LTR_A;
      {3'd2, 4'b0010}: idx = LTR_N;
      {3'd2, 4'b0011}: idx = LTR_M;
      {3'd3, 4'b0000}: idx = LTR_S;
      {3'd3, 4'b0001}: idx = LTR_U;
      {3'd3, 4'b0010}: idx = LTR_R;
      {3'd3, 4'b0011}: idx = LTR_W;
      {3'd3, 4'b0100}: idx = LTR_D;
      {3'd3, 4'b0101}: idx = LTR_K;
      {3'd3, 4'b0110}: idx = LTR_G;
      {3'd3, 4'b0111}: idx = LTR_O;
      {3'd4, 4'b0000}: idx = LTR_H;
      {3'd4, 4'b0001}: idx = LTR_V;
      {3'd4, 4'b0010}: idx = LTR_F;
      {3'd4, 4'b0100}: idx = LTR_L;
      {3'd4, 4'b0110}: idx = LTR_P;
      {3'd4, 4'b0111}: idx = LTR_J;
      {3'd4, 4'b1000}: idx = LTR_B;
      {3'd4, 4'b1001}: idx = LTR_X;
      {3'd4, 4'b1010}: idx = LTR_C;
      {3'd4, 4'b1011}: idx = LTR_Y;
      {3'd4, 4'b1100}: idx = LTR_Z;
      {3'd4, 4'b1101}: idx = LTR_Q;
      default:         valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Samples a raw Morse key, times marks and spaces in prescaled units and
// emits one decoded letter (or an error strobe) per letter gap.
//   state | meaning
//   IDLE  | waiting for the first key-down of a letter
//   MARK  | key down, timing the mark
//   SPACE | key up, timing the gap after a symbol
//   EMIT  | one-cycle letter lookup and symbol register clear
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DASH_UNITS = DEF_DASH_UNITS,
  parameter int LETTER_GAP = DEF_LETTER_GAP,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  morse_key_decoder_if.slave kif
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(LETTER_GAP);

  logic             key_m, key_s, key_d, key_edge, tick;
  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] unit_cnt;
  logic [3:0]       pattern;
  logic [2:0]       len;
  logic             ovf, shift_en, lut_valid;
  logic [4:0]       lut_idx;
  state_t           state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
      key_d <= 1'b0;
    end else begin
      key_m <= kif.key;
      key_s <= key_m;
      key_d <= key_s;
    end
  end

  assign key_edge = key_s ^ key_d;
  assign tick     = (pre_cnt == PRE_MAX) && !key_edge;

  // Both timers restart on every key edge so marks and spaces are timed from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      unit_cnt <= '0;
    end else begin
      if (key_edge || pre_cnt == PRE_MAX) pre_cnt <= '0;
      else                                pre_cnt <= pre_cnt + 1'b1;
      if (key_edge)                           unit_cnt <= '0;
      else if (tick && unit_cnt != '1)        unit_cnt <= unit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE:  if (key_s) state_nxt = ST_MARK;
      ST_MARK:  if (!key_s) begin
                  shift_en  = 1'b1;
                  state_nxt = ST_SPACE;
                end
      ST_SPACE: if (key_s && unit_cnt < GAP_CNT) state_nxt = ST_MARK;
                else if (unit_cnt >= GAP_CNT)    state_nxt = ST_EMIT;
      ST_EMIT:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
      len     <= '0;
      ovf     <= 1'b0;
    end else if (shift_en) begin
      if (len == 3'd4) ovf <= 1'b1;
      else begin
        pattern <= {pattern[2:0], unit_cnt >= DASH_CNT};
        len     <= len + 1'b1;
      end
    end else if (state == ST_EMIT) begin
      pattern <= '0;
      len     <= '0;
      ovf     <= 1'b0;
    end
  end

  morse_code_lut u_lut (
    .len     (len),
    .pattern (pattern),
    .idx     (lut_idx),
    .valid   (lut_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kif.letter       <= '0;
      kif.letter_valid <= 1'b0;
      kif.error        <= 1'b0;
    end else begin
      kif.letter_valid <= 1'b0;
      kif.error        <= 1'b0;
      if (state == ST_EMIT) begin
        if (lut_valid && !ovf) begin
          kif.letter       <= lut_idx;
          kif.letter_valid <= 1'b1;
        end else begin
          kif.error <= 1'b1;
        end
      end
    end
  end

  assign kif.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder: dot = 4 cycles, dash = 12 cycles,
// symbol gap = 4 cycles, letter gap = 24 cycles (TICK_DIV=4).
module tb_morse_key_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_valid = 0;
  int   n_err = 0;

  morse_key_decoder_if kif ();

  morse_key_decoder #(
    .TICK_DIV   (4),
    .DASH_UNITS (2),
    .LETTER_GAP (3),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (kif.letter_valid) n_valid++;
      if (kif.error)        n_err++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sym(input bit dash);
    kif.key = 1'b1;
    cyc(dash ? 12 : 4);
    kif.key = 1'b0;
    cyc(4);
  endtask

  task automatic end_letter();
    cyc(20);
  endtask

  initial begin
    kif.key = 1'b0;
    cyc(3);
    chk("rst_letter", 32'(kif.letter), 0);
    chk("rst_valid", 32'(kif.letter_valid), 0);
    chk("rst_error", 32'(kif.error), 0);
    chk("rst_busy", 32'(kif.busy), 0);
    rst_n = 1'b1;
    cyc(2);

    // E
    sym(0); end_letter();
    chk("e_valid_cnt", n_valid, 1);
    chk("e_err_cnt", n_err, 0);
    chk("e_letter", 32'(kif.letter), 4);
    chk("e_busy", 32'(kif.busy), 0);

    // A, then O
    sym(0);
    chk("a_busy_mid", 32'(kif.busy), 1);
    sym(1); end_letter();
    chk("a_valid_cnt", n_valid, 2);
    chk("a_letter", 32'(kif.letter), 0);
    sym(1); sym(1); sym(1); end_letter();
    chk("o_valid_cnt", n_valid, 3);
    chk("o_letter", 32'(kif.letter), 14);
    cyc(30);
    chk("o_hold", 32'(kif.letter), 14);
    chk("o_no_extra", n_valid, 3);

    // Q, then invalid 1111
    sym(1); sym(1); sym(0); sym(1); end_letter();
    chk("q_valid_cnt", n_valid, 4);
    chk("q_letter", 32'(kif.letter), 16);
    sym(1); sym(1); sym(1); sym(1); end_letter();
    chk("bad_err_cnt", n_err, 1);
    chk("bad_valid_cnt", n_valid, 4);
    chk("bad_letter", 32'(kif.letter), 16);

    // five dots overflow, then E
    for (int i = 0; i < 5; i++) sym(0);
    end_letter();
    chk("ovf_err_cnt", n_err, 2);
    chk("ovf_valid_cnt", n_valid, 4);
    chk("ovf_letter", 32'(kif.letter), 16);
    sym(0); end_letter();
    chk("ovf_e_valid_cnt", n_valid, 5);
    chk("ovf_e_letter", 32'(kif.letter), 4);

    // long hold saturates the unit counter, decodes as T
    kif.key = 1'b1;
    cyc(500);
    chk("hold_busy", 32'(kif.busy), 1);
    chk("hold_no_strobe", n_valid, 5);
    kif.key = 1'b0;
    cyc(24);
    chk("t_valid_cnt", n_valid, 6);
    chk("t_letter", 32'(kif.letter), 19);
    chk("t_busy", 32'(kif.busy), 0);

    // async reset during the second symbol of A
    sym(0);
    kif.key = 1'b1;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_letter", 32'(kif.letter), 0);
    chk("mid_rst_busy", 32'(kif.busy), 0);
    chk("mid_rst_valid", 32'(kif.letter_valid), 0);
    chk("mid_rst_error", 32'(kif.error), 0);
    kif.key = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(24);
    chk("post_rst_valid_cnt", n_valid, 6);
    chk("post_rst_err_cnt", n_err, 2);
    chk("post_rst_busy", 32'(kif.busy), 0);
    sym(0); end_letter();
    chk("post_rst_e_cnt", n_valid, 7);
    chk("post_rst_e_letter", 32'(kif.letter), 4);
    chk("final_err_cnt", n_err, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Upstream stage of the Morse letter display path: samples a single raw Morse key input, classifies each key-down period as dot or dash, and groups symbols into letters using inter-symbol gap timing.
- Emits a 5-bit letter index (A=0 … Z=25) with a one-cycle valid strobe, which drives the display stage's start input.
- Reports malformed codes on a separate one-cycle error strobe.

Parameters:
- TICK_DIV, 1000: clk cycles per timing unit (prescaler terminal count); legal range ≥1.
- DASH_UNITS, 2: mark length in units at or above which a symbol is a dash; shorter marks are dots.
- LETTER_GAP, 3: space length in units that terminates a letter.
- CNT_W, 8: width of the unit counter; the counter saturates at 2^CNT_W−1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- key_i  in  1  raw Morse key, asynchronous, high = key down
- letter_o  out  5  decoded letter index; holds the last valid letter
- letter_valid_o  out  1  one-cycle strobe; letter_o is valid in this cycle
- error_o  out  1  one-cycle strobe for an undecodable or over-long code
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0) forces all outputs to 0, state to IDLE, pattern, length and counters to 0, and the synchronizer to 0.
- key_i passes through a 2-FF synchronizer; key_s is the synchronized level, so the FSM sees input edges 2 cycles late.
- Prescaler:
  - Counts 0..TICK_DIV−1 and asserts tick for one cycle at terminal count.
  - Restarts from 0 on every key_s edge.
- Unit counter (unit_cnt):
  - Cleared on every key_s edge; increments on tick and saturates.
  - A key held indefinitely keeps the FSM in MARK with a saturated counter.
- Symbol register: pattern[3:0] and len[2:0], plus an overflow flag.
  - Each new symbol shifts into the LSB (pattern = {pattern[2:0], sym}); dot=0, dash=1; the first symbol therefore ends up most significant.
- FSM states:
  - IDLE: busy_o=0. key_s rises → MARK.
  - MARK: on key_s fall, sym = (unit_cnt ≥ DASH_UNITS). If len==4, set overflow and leave pattern unchanged; else shift and increment len. → SPACE.
  - SPACE: key_s rises before unit_cnt reaches LETTER_GAP → MARK. unit_cnt == LETTER_GAP → EMIT.
  - EMIT (one cycle): look up {len, pattern}.
    - Valid and no overflow → letter_o <= index, letter_valid_o=1.
    - Otherwise → error_o=1 and letter_o is unchanged.
    - Then clear pattern, len and overflow → IDLE.
- Strobe timing: both strobes are registered and appear in the cycle after EMIT. Neither is ever asserted together with the other, and neither is ever high for two consecutive cycles.
- Lookup, written as len:pattern → letter:
  - len 1: 0→E(4), 1→T(19).
  - len 2: 00→I, 01→A, 10→N, 11→M.
  - len 3: 000→S, 001→U, 010→R, 011→W, 100→D, 101→K, 110→G, 111→O.
  - len 4: 0000→H, 0001→V, 0010→F, 0100→L, 0110→P, 0111→J, 1000→B, 1001→X, 1010→C, 1011→Y, 1100→Z, 1101→Q.
  - len 4 codes 0011, 0101, 1110 and 1111 are invalid and raise error_o.
- Key activity in EMIT is ignored; a key_s rise in that cycle is picked up from IDLE on the next cycle.
- If rst_n is asserted mid-letter, the partial letter is discarded and no strobe is produced.

Decomposition:
- Shared package morse_pkg:
  - FSM state encoding (IDLE, MARK, SPACE, EMIT).
  - Letter index constants (LTR_A..LTR_Z).
  - Default timing parameters.
- Combinational sub-module morse_code_lut: inputs len[2:0] and pattern[3:0]; outputs idx[4:0] and valid.

Test Plan (TICK_DIV=4, DASH_UNITS=2, LETTER_GAP=3):
- Key high 4 cycles (1 unit), then low for 16 cycles → one letter_valid_o with letter_o=4 (E); busy_o returns to 0.
- Dot, dash, with a 1-unit gap between them, then a 4-unit gap → letter_o=0 (A); then dash×3 → letter_o=14 (O), and letter_o holds 14 afterwards.
- Pattern dash,dash,dot,dash → letter_o=16 (Q); pattern dash×4 → error_o single pulse, letter_valid_o stays 0, letter_o unchanged.
- Five dots before the letter gap → error_o pulse (overflow); the next letter E decodes correctly.
- Key held 500 cycles → counter saturates, no hang; on release and gap, letter_o=19 (T).
- rst_n pulsed low asynchronously during the second symbol of A → outputs go to 0 immediately, no strobe; the following E decodes normally.
